// File: rtl/imu_init_pkg.sv
// imu_init_pkg: shared types and constants for the IMU init sequencer.
// Entry word layout is {reg[7:0], data[7:0], delay[7:0]}.
package imu_init_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_ACK,
    S_DELAY,
    S_NEXT,
    S_FAULT
  } state_e;

  localparam int ENTRY_W = 24;

  localparam int REG_HI = 23;
  localparam int REG_LO = 16;
  localparam int DAT_HI = 15;
  localparam int DAT_LO = 8;
  localparam int DLY_HI = 7;
  localparam int DLY_LO = 0;

  localparam logic [6:0] MPU9250_ADDR = 7'h68;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t mk_entry(
    input logic [7:0] r,
    input logic [7:0] d,
    input logic [7:0] dly
  );
    return {r, d, dly};
  endfunction

endpackage

// File: rtl/imu_init_rom.sv
// imu_init_rom: fixed MPU9250 bring-up table, one 24-bit word per entry.
// Unused indices read as all-zero words.
module imu_init_rom
  import imu_init_pkg::*;
(
  input  logic [3:0] idx_i,
  output entry_t     entry_o
);

  // Combinational table lookup
  always_comb begin
    entry_o = '0;
    case (idx_i)
      4'd0:    entry_o = mk_entry(8'h6B, 8'h80, 8'd100);
      4'd1:    entry_o = mk_entry(8'h6B, 8'h01, 8'd10);
      4'd2:    entry_o = mk_entry(8'h1A, 8'h03, 8'd0);
      4'd3:    entry_o = mk_entry(8'h1B, 8'h18, 8'd0);
      4'd4:    entry_o = mk_entry(8'h1C, 8'h08, 8'd0);
      4'd5:    entry_o = mk_entry(8'h1D, 8'h03, 8'd0);
      4'd6:    entry_o = mk_entry(8'h37, 8'h02, 8'd0);
      4'd7:    entry_o = mk_entry(8'h6C, 8'h00, 8'd0);
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/imu_init_sequencer.sv
// imu_init_sequencer: walks the init table into the I2C byte writer.
// Optional write watchdog enabled by defining INIT_TIMEOUT_EN.
module imu_init_sequencer
  import imu_init_pkg::*;
#(
  parameter int         NUM_ENTRIES       = 8,
  parameter logic [6:0] DEVICE_ADDR       = MPU9250_ADDR,
  parameter int         DELAY_UNIT_CYCLES = 25000,
  parameter int         TIMEOUT_CYCLES    = 250000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       wr_done,
  output logic       wr_start,
  output logic [6:0] device_address,
  output logic [7:0] register_address,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [3:0] entry_idx
);

  localparam logic [3:0] LAST_IDX =
    4'(NUM_ENTRIES - 1);
  localparam logic [31:0] UNIT =
    32'(DELAY_UNIT_CYCLES);

  state_e      state_q;
  logic        done_meta_q;
  logic        done_sync_q;
  logic [3:0]  idx_q;
  logic [7:0]  reg_q;
  logic [7:0]  dat_q;
  logic [7:0]  dly_q;
  logic [31:0] dly_cnt_q;
  logic        wr_start_q;
  logic        busy_q;
  logic        init_done_q;
  entry_t      rom_word;

`ifdef INIT_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST =
    32'(TIMEOUT_CYCLES - 1);
  logic        error_q;
  logic [31:0] tmo_q;
  logic        tmo_hit;
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign error   = error_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign error      = 1'b0;
`endif

  imu_init_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_word)
  );

  // Two-flop synchronizer for the writer's done level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
    end else begin
      done_meta_q <= wr_done;
      done_sync_q <= done_meta_q;
    end
  end

  // Sequencer FSM; every output is registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      reg_q       <= '0;
      dat_q       <= '0;
      dly_q       <= '0;
      dly_cnt_q   <= '0;
      wr_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
`ifdef INIT_TIMEOUT_EN
      error_q     <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          wr_start_q <= 1'b0;
          if (go) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            idx_q       <= '0;
`ifdef INIT_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          reg_q      <= rom_word[REG_HI:REG_LO];
          dat_q      <= rom_word[DAT_HI:DAT_LO];
          dly_q      <= rom_word[DLY_HI:DLY_LO];
          wr_start_q <= 1'b1;
          state_q    <= S_REQ;
`ifdef INIT_TIMEOUT_EN
          tmo_q      <= '0;
`endif
        end
        S_REQ: begin
`ifdef INIT_TIMEOUT_EN
          tmo_q <= tmo_q + 32'd1;
          if (tmo_hit) begin
            state_q    <= S_FAULT;
            wr_start_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
          end else
`endif
          if (!done_sync_q) begin
            wr_start_q <= 1'b0;
            state_q    <= S_ACK;
          end
        end
        S_ACK: begin
          wr_start_q <= 1'b0;
`ifdef INIT_TIMEOUT_EN
          tmo_q <= tmo_q + 32'd1;
          if (tmo_hit) begin
            state_q <= S_FAULT;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else
`endif
          if (done_sync_q) begin
            dly_cnt_q <= 32'(dly_q) * UNIT;
            state_q   <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (dly_cnt_q <= 32'd1) begin
            state_q <= S_NEXT;
          end else begin
            dly_cnt_q <= dly_cnt_q - 32'd1;
          end
        end
        S_NEXT: begin
          if (idx_q == LAST_IDX) begin
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= S_LOAD;
          end
        end
        default: begin
          wr_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_start         = wr_start_q;
  assign device_address   = DEVICE_ADDR;
  assign register_address = reg_q;
  assign data_out         = dat_q;
  assign busy             = busy_q;
  assign init_done        = init_done_q;
  assign entry_idx        = idx_q;

endmodule
